// File: rtl/qbus_dma_master_if.sv
// Qbus DMA master signal bundle: command/response handshake plus raw Qbus
// receivers and driver controls. The master modport is the DMA engine's view.
interface qbus_dma_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic        cmd_byte;
   logic [21:0] cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_timeout;
   logic        bus_owned;
   logic [21:0] BDALf_IN;
   logic        BRPLYf;
   logic        BINITf;
   logic [21:0] BDALf_OUT;
   logic [21:0] BDALf_OE;
   logic        Outbound;
   logic        BSYNCg;
   logic        BDINg;
   logic        BDOUTg;
   logic        BWTBTg;
   logic        BBS7g;

   modport master (
      input  cmd_valid, cmd_write, cmd_byte, cmd_addr, cmd_wdata, bus_owned,
             BDALf_IN, BRPLYf, BINITf,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
             BDALf_OUT, BDALf_OE, Outbound, BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_byte, cmd_addr, cmd_wdata, bus_owned,
             BDALf_IN, BRPLYf, BINITf,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
             BDALf_OUT, BDALf_OE, Outbound, BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g
   );
endinterface

// File: rtl/qbus_dma_master.sv
// Qbus DMA bus-cycle master: runs one DATI/DATO/DATOB cycle per accepted
// command with programmable setup/hold/deskew timing and reply timeouts.
module qbus_dma_master #(
   parameter int unsigned T_SETUP   = 15,
   parameter int unsigned T_HOLD    = 10,
   parameter int unsigned T_DESKEW  = 10,
   parameter int unsigned T_TIMEOUT = 1000
) (
   input  logic              clock,
   input  logic              RSTN,
   qbus_dma_master_if.master bus
);
   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] ADDR       = 3'd1;
   localparam logic [2:0] SYNC       = 3'd2;
   localparam logic [2:0] DATA       = 3'd3;
   localparam logic [2:0] WAIT_RPLY  = 3'd4;
   localparam logic [2:0] WAIT_NRPLY = 3'd5;
   localparam logic [2:0] DONE       = 3'd6;

   localparam int unsigned T_A   = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
   localparam int unsigned T_B   = (T_DESKEW > T_TIMEOUT) ? T_DESKEW : T_TIMEOUT;
   localparam int unsigned T_MAX = (T_A > T_B) ? T_A : T_B;
   localparam int unsigned CW    = $clog2(T_MAX + 1);

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [1:0]    rply_sync;
   logic [1:0]    init_sync;
   logic          rply;
   logic          init;
   logic          ready_en;
   logic          ready;
   logic          accept;
   logic          lat_write;
   logic          lat_byte;
   logic [21:0]   lat_addr;
   logic [15:0]   lat_wdata;
   logic [15:0]   rdata;
   logic          timed_out;
   logic          unused_hi;

   assign rply      = ~rply_sync[1];
   assign init      = ~init_sync[1];
   assign ready     = ready_en && (state == IDLE) && !init;
   assign accept    = bus.cmd_valid && ready && bus.bus_owned;
   assign unused_hi = ^bus.BDALf_IN[21:16];

   assign bus.cmd_ready   = ready;
   assign bus.rsp_valid   = (state == DONE) && !init;
   assign bus.rsp_timeout = (state == DONE) && !init && timed_out;
   assign bus.rsp_rdata   = rdata;

   always_ff @(posedge clock or negedge RSTN) begin
      if (!RSTN) begin
         state     <= IDLE;
         cnt       <= '0;
         rply_sync <= '1;
         init_sync <= '1;
         ready_en  <= 1'b0;
         lat_write <= 1'b0;
         lat_byte  <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata     <= '0;
         timed_out <= 1'b0;
      end else begin
         rply_sync <= {rply_sync[0], bus.BRPLYf};
         init_sync <= {init_sync[0], bus.BINITf};
         ready_en  <= 1'b1;
         cnt       <= cnt + CW'(1);
         if (init) begin
            state     <= IDLE;
            cnt       <= '0;
            timed_out <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (accept) begin
                     state     <= ADDR;
                     lat_write <= bus.cmd_write;
                     lat_byte  <= bus.cmd_byte & bus.cmd_write;
                     lat_addr  <= bus.cmd_addr;
                     lat_wdata <= bus.cmd_wdata;
                     rdata     <= '0;
                     timed_out <= 1'b0;
                  end
               end
               ADDR: if (cnt == CW'(T_SETUP - 1)) begin
                  state <= SYNC;
                  cnt   <= '0;
               end
               SYNC: if (cnt == CW'(T_HOLD - 1)) begin
                  state <= DATA;
                  cnt   <= '0;
               end
               DATA: if (!lat_write || cnt == CW'(T_DESKEW - 1)) begin
                  state <= WAIT_RPLY;
                  cnt   <= '0;
               end
               // A reply seen on the final timeout clock still counts as a reply.
               WAIT_RPLY: if (rply) begin
                  if (!lat_write) rdata <= ~bus.BDALf_IN[15:0];
                  state <= WAIT_NRPLY;
                  cnt   <= '0;
               end else if (cnt == CW'(T_TIMEOUT - 1)) begin
                  state     <= DONE;
                  timed_out <= 1'b1;
                  rdata     <= '0;
               end
               WAIT_NRPLY: if (!rply) begin
                  state <= DONE;
               end else if (cnt == CW'(T_TIMEOUT - 1)) begin
                  state     <= DONE;
                  timed_out <= 1'b1;
                  rdata     <= '0;
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      bus.BDALf_OUT = '0;
      bus.BDALf_OE  = '0;
      bus.Outbound  = 1'b0;
      bus.BSYNCg    = 1'b0;
      bus.BDINg     = 1'b0;
      bus.BDOUTg    = 1'b0;
      bus.BWTBTg    = 1'b0;
      bus.BBS7g     = 1'b0;
      case (state)
         ADDR, SYNC: begin
            bus.BDALf_OUT = lat_addr;
            bus.BDALf_OE  = '1;
            bus.Outbound  = 1'b1;
            bus.BWTBTg    = lat_write;
            bus.BBS7g     = (lat_addr[21:13] == 9'h1FF);
            bus.BSYNCg    = (state == SYNC);
         end
         DATA, WAIT_RPLY, WAIT_NRPLY: begin
            bus.BSYNCg = 1'b1;
            if (lat_write) begin
               bus.BDALf_OUT = {6'b0, lat_wdata};
               bus.BDALf_OE  = '1;
               bus.Outbound  = 1'b1;
               bus.BWTBTg    = lat_byte;
            end
            bus.BDINg  = !lat_write && (state != WAIT_NRPLY);
            bus.BDOUTg = lat_write && (state == WAIT_RPLY);
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_qbus_dma_master.sv
// Directed bench for qbus_dma_master: cycle-by-cycle timelines with
// hand-computed expectations, sampled on the falling clock edge.
module tb_qbus_dma_master;
   logic clock;
   logic RSTN;
   int   n_cmp;
   int   n_bad;

   qbus_dma_master_if bus();

   qbus_dma_master #(
      .T_SETUP  (15),
      .T_HOLD   (10),
      .T_DESKEW (10),
      .T_TIMEOUT(1000)
   ) dut (
      .clock(clock),
      .RSTN (RSTN),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g, Outbound, rsp_valid}
   function automatic logic [6:0] gates();
      return {bus.BSYNCg, bus.BDINg, bus.BDOUTg, bus.BWTBTg, bus.BBS7g,
              bus.Outbound, bus.rsp_valid};
   endfunction

   // Presents a command for one clock; returns on the falling edge after acceptance.
   task automatic issue(input logic w, input logic b, input logic [21:0] a,
                        input logic [15:0] d);
      @(negedge clock);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_byte  = b;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      @(negedge clock);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      n_cmp++;
      if ({gates(), bus.BDALf_OE, bus.cmd_ready, bus.rsp_timeout, bus.rsp_rdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs got gates=%b oe=%h rdy=%b to=%b rdata=%h want all 0",
                  gates(), bus.BDALf_OE, bus.cmd_ready, bus.rsp_timeout, bus.rsp_rdata);
      end
      RSTN = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (bus.cmd_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_ready got %b want 1", bus.cmd_ready);
      end
   endtask

   task automatic test_read();
      logic [6:0] exp;
      bus.BDALf_IN = {6'h3F, ~16'o123456};
      issue(1'b0, 1'b0, 22'o00001000, 16'h0);
      for (int k = 1; k <= 53; k++) begin
         if (k > 1) @(negedge clock);
         if (k <= 15)      exp = 7'b0000010;
         else if (k <= 25) exp = 7'b1000010;
         else if (k <= 48) exp = 7'b1100000;
         else if (k <= 51) exp = 7'b1000000;
         else if (k == 52) exp = 7'b0000001;
         else              exp = 7'b0000000;
         n_cmp++;
         if (gates() !== exp) begin
            n_bad++; $display("FAIL read_gates k=%0d got %b want %b", k, gates(), exp);
         end
         if (k == 1) begin
            n_cmp++;
            if (bus.BDALf_OUT !== 22'o00001000 || bus.BDALf_OE !== 22'h3FFFFF) begin
               n_bad++; $display("FAIL read_addr got %o oe=%h want 1000 oe=3fffff",
                                 bus.BDALf_OUT, bus.BDALf_OE);
            end
         end
         if (k == 26) begin
            n_cmp++;
            if (bus.BDALf_OE !== '0) begin
               n_bad++; $display("FAIL read_release got oe=%h want 0", bus.BDALf_OE);
            end
         end
         if (k == 52) begin
            n_cmp++;
            if (bus.rsp_rdata !== 16'o123456 || bus.rsp_timeout !== 1'b0) begin
               n_bad++; $display("FAIL read_data got %o to=%b want 123456 to=0",
                                 bus.rsp_rdata, bus.rsp_timeout);
            end
         end
         if (k == 46) bus.BRPLYf = 1'b0;
         if (k == 49) bus.BRPLYf = 1'b1;
      end
   endtask

   task automatic test_write_byte();
      logic [6:0] exp;
      issue(1'b1, 1'b1, 22'o17772153, 16'hAB00);
      for (int k = 1; k <= 47; k++) begin
         if (k > 1) @(negedge clock);
         if (k <= 15)      exp = 7'b0001110;
         else if (k <= 25) exp = 7'b1001110;
         else if (k <= 35) exp = 7'b1001010;
         else if (k <= 42) exp = 7'b1011010;
         else if (k <= 45) exp = 7'b1001010;
         else if (k == 46) exp = 7'b0000001;
         else              exp = 7'b0000000;
         n_cmp++;
         if (gates() !== exp) begin
            n_bad++; $display("FAIL write_gates k=%0d got %b want %b", k, gates(), exp);
         end
         if (k == 1) begin
            n_cmp++;
            if (bus.BDALf_OUT !== 22'o17772153) begin
               n_bad++; $display("FAIL write_addr got %o want 17772153", bus.BDALf_OUT);
            end
         end
         if (k == 30) begin
            n_cmp++;
            if (bus.BDALf_OUT !== 22'h00AB00 || bus.BDALf_OE !== 22'h3FFFFF) begin
               n_bad++; $display("FAIL write_data got %h oe=%h want 00ab00 oe=3fffff",
                                 bus.BDALf_OUT, bus.BDALf_OE);
            end
         end
         if (k == 46) begin
            n_cmp++;
            if (bus.rsp_rdata !== 16'h0 || bus.rsp_timeout !== 1'b0) begin
               n_bad++; $display("FAIL write_rsp got rdata=%h to=%b want 0 0",
                                 bus.rsp_rdata, bus.rsp_timeout);
            end
         end
         if (k == 40) bus.BRPLYf = 1'b0;
         if (k == 43) bus.BRPLYf = 1'b1;
      end
   endtask

   task automatic test_read_timeout();
      issue(1'b0, 1'b0, 22'o00002000, 16'h0);
      for (int k = 1; k <= 1028; k++) begin
         if (k > 1) @(negedge clock);
         if (k == 27 || k == 1026) begin
            n_cmp++;
            if (gates() !== 7'b1100000) begin
               n_bad++; $display("FAIL tmo_wait k=%0d got %b want 1100000", k, gates());
            end
         end
         if (k == 1027) begin
            n_cmp++;
            if (gates() !== 7'b0000001 || bus.rsp_timeout !== 1'b1 || bus.rsp_rdata !== 16'h0) begin
               n_bad++; $display("FAIL tmo_done got %b to=%b rdata=%h want 0000001 1 0",
                                 gates(), bus.rsp_timeout, bus.rsp_rdata);
            end
         end
         if (k == 1028) begin
            n_cmp++;
            if (gates() !== 7'b0000000) begin
               n_bad++; $display("FAIL tmo_idle got %b want 0", gates());
            end
         end
      end
   endtask

   task automatic test_nrply_timeout();
      bus.BDALf_IN = {6'h3F, ~16'hBEEF};
      issue(1'b0, 1'b0, 22'o00002004, 16'h0);
      for (int k = 1; k <= 1036; k++) begin
         if (k > 1) @(negedge clock);
         if (k == 33 || k == 1032) begin
            n_cmp++;
            if (gates() !== 7'b1000000) begin
               n_bad++; $display("FAIL nrply_wait k=%0d got %b want 1000000", k, gates());
            end
         end
         if (k == 1033) begin
            n_cmp++;
            if (gates() !== 7'b0000001 || bus.rsp_timeout !== 1'b1 || bus.rsp_rdata !== 16'h0) begin
               n_bad++; $display("FAIL nrply_done got %b to=%b rdata=%h want 0000001 1 0",
                                 gates(), bus.rsp_timeout, bus.rsp_rdata);
            end
         end
         if (k == 30)   bus.BRPLYf = 1'b0;
         if (k == 1033) bus.BRPLYf = 1'b1;
      end
   endtask

   task automatic test_bus_owned();
      @(negedge clock);
      bus.bus_owned = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_byte  = 1'b0;
      bus.cmd_addr  = 22'o00004000;
      bus.cmd_wdata = 16'h1234;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         n_cmp++;
         if (gates() !== 7'b0000000 || bus.cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL own_hold i=%0d got %b rdy=%b want 0 rdy=1",
                              i, gates(), bus.cmd_ready);
         end
      end
      bus.bus_owned = 1'b1;
      for (int k = 1; k <= 47; k++) begin
         @(negedge clock);
         if (k == 1) begin
            n_cmp++;
            if (gates() !== 7'b0001010 || bus.BDALf_OUT !== 22'o00004000) begin
               n_bad++; $display("FAIL own_accept got %b addr=%o want 0001010 4000",
                                 gates(), bus.BDALf_OUT);
            end
            bus.cmd_valid = 1'b0;
         end
         if (k == 2) bus.bus_owned = 1'b0;
         if (k == 30) begin
            n_cmp++;
            if (gates() !== 7'b1000010 || bus.BDALf_OUT !== 22'h001234) begin
               n_bad++; $display("FAIL own_data got %b d=%h want 1000010 001234",
                                 gates(), bus.BDALf_OUT);
            end
         end
         if (k == 46) begin
            n_cmp++;
            if (gates() !== 7'b0000001 || bus.rsp_timeout !== 1'b0) begin
               n_bad++; $display("FAIL own_complete got %b to=%b want 0000001 0",
                                 gates(), bus.rsp_timeout);
            end
         end
         if (k == 40) bus.BRPLYf = 1'b0;
         if (k == 43) bus.BRPLYf = 1'b1;
      end
      bus.bus_owned = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic extra_ready;
      extra_ready = 1'b0;
      bus.BDALf_IN = {6'h3F, ~16'h5A5A};
      @(negedge clock);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_byte  = 1'b0;
      bus.cmd_addr  = 22'o00001002;
      bus.cmd_wdata = 16'h0;
      for (int k = 1; k <= 94; k++) begin
         @(negedge clock);
         if (k == 1) begin
            bus.cmd_write = 1'b1;
            bus.cmd_addr  = 22'o00003000;
            bus.cmd_wdata = 16'hC3C3;
         end
         if (k >= 2 && k <= 45 && bus.cmd_ready === 1'b1) extra_ready = 1'b1;
         if (k == 10) begin
            n_cmp++;
            if (bus.BDALf_OUT !== 22'o00001002 || bus.BWTBTg !== 1'b0) begin
               n_bad++; $display("FAIL b2b_latch got %o w=%b want 1002 w=0",
                                 bus.BDALf_OUT, bus.BWTBTg);
            end
         end
         if (k == 46) begin
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'h5A5A) begin
               n_bad++; $display("FAIL b2b_first got v=%b rdata=%h want 1 5a5a",
                                 bus.rsp_valid, bus.rsp_rdata);
            end
         end
         if (k == 47) begin
            n_cmp++;
            if (bus.cmd_ready !== 1'b1 || bus.Outbound !== 1'b0 || bus.rsp_valid !== 1'b0) begin
               n_bad++; $display("FAIL b2b_gap got rdy=%b ob=%b v=%b want 1 0 0",
                                 bus.cmd_ready, bus.Outbound, bus.rsp_valid);
            end
         end
         if (k == 48) begin
            n_cmp++;
            if (bus.Outbound !== 1'b1 || bus.BDALf_OUT !== 22'o00003000 ||
                bus.BWTBTg !== 1'b1 || bus.cmd_ready !== 1'b0) begin
               n_bad++; $display("FAIL b2b_second got ob=%b a=%o w=%b rdy=%b want 1 3000 1 0",
                                 bus.Outbound, bus.BDALf_OUT, bus.BWTBTg, bus.cmd_ready);
            end
            bus.cmd_valid = 1'b0;
         end
         if (k == 75) begin
            n_cmp++;
            if (bus.BDALf_OUT !== 22'h00C3C3) begin
               n_bad++; $display("FAIL b2b_wdata got %h want 00c3c3", bus.BDALf_OUT);
            end
         end
         if (k == 93) begin
            n_cmp++;
            if (gates() !== 7'b0000001 || bus.rsp_rdata !== 16'h0 || bus.rsp_timeout !== 1'b0) begin
               n_bad++; $display("FAIL b2b_done got %b rdata=%h to=%b want 0000001 0 0",
                                 gates(), bus.rsp_rdata, bus.rsp_timeout);
            end
         end
         if (k == 40 || k == 87) bus.BRPLYf = 1'b0;
         if (k == 43 || k == 90) bus.BRPLYf = 1'b1;
      end
      n_cmp++;
      if (extra_ready !== 1'b0) begin
         n_bad++; $display("FAIL b2b_busy got ready_seen=%b want 0", extra_ready);
      end
   endtask

   task automatic test_binit();
      logic rv_seen;
      rv_seen = 1'b0;
      issue(1'b0, 1'b0, 22'o00001000, 16'h0);
      for (int k = 1; k <= 44; k++) begin
         if (k > 1) @(negedge clock);
         if (k >= 31 && bus.rsp_valid === 1'b1) rv_seen = 1'b1;
         if (k == 31) begin
            n_cmp++;
            if (gates() !== 7'b1100000) begin
               n_bad++; $display("FAIL init_before got %b want 1100000", gates());
            end
         end
         if (k == 33) begin
            n_cmp++;
            if (gates() !== 7'b0000000 || bus.BDALf_OE !== '0 || bus.cmd_ready !== 1'b0) begin
               n_bad++; $display("FAIL init_abort got %b oe=%h rdy=%b want 0 0 0",
                                 gates(), bus.BDALf_OE, bus.cmd_ready);
            end
         end
         if (k == 40) begin
            n_cmp++;
            if (bus.cmd_ready !== 1'b0) begin
               n_bad++; $display("FAIL init_ready_low got %b want 0", bus.cmd_ready);
            end
            bus.BINITf = 1'b1;
         end
         if (k == 44) begin
            n_cmp++;
            if (bus.cmd_ready !== 1'b1 || gates() !== 7'b0000000) begin
               n_bad++; $display("FAIL init_recover got rdy=%b g=%b want 1 0",
                                 bus.cmd_ready, gates());
            end
         end
         if (k == 30) bus.BINITf = 1'b0;
      end
      n_cmp++;
      if (rv_seen !== 1'b0) begin
         n_bad++; $display("FAIL init_no_rsp got rsp_valid_seen=%b want 0", rv_seen);
      end
   endtask

   task automatic test_rstn_async();
      issue(1'b1, 1'b0, 22'o00005000, 16'h0F0F);
      for (int k = 2; k <= 20; k++) @(negedge clock);
      n_cmp++;
      if (bus.BSYNCg !== 1'b1) begin
         n_bad++; $display("FAIL rst_presync got %b want 1", bus.BSYNCg);
      end
      #2 RSTN = 1'b0;
      #1;
      n_cmp++;
      if ({gates(), bus.BDALf_OE, bus.cmd_ready} !== '0) begin
         n_bad++; $display("FAIL rst_async got g=%b oe=%h rdy=%b want all 0",
                           gates(), bus.BDALf_OE, bus.cmd_ready);
      end
      @(negedge clock);
      RSTN = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (bus.cmd_ready !== 1'b1 || gates() !== 7'b0000000) begin
         n_bad++; $display("FAIL rst_release got rdy=%b g=%b want 1 0", bus.cmd_ready, gates());
      end
   endtask

   initial begin
      n_cmp         = 0;
      n_bad         = 0;
      RSTN          = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_byte  = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.bus_owned = 1'b1;
      bus.BDALf_IN  = '1;
      bus.BRPLYf    = 1'b1;
      bus.BINITf    = 1'b1;
      test_reset();
      test_read();
      test_write_byte();
      test_read_timeout();
      test_nrply_timeout();
      test_bus_owned();
      test_back_to_back();
      test_binit();
      test_rstn_async();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/qbus_dma_master.md
QBUS_DMA_MASTER -- requirements
Module: qbus_dma_master

Interface
REQ-001 SHALL have parameter T_SETUP, default 15: clocks address is driven before BSYNCg asserts.
REQ-002 SHALL have parameter T_HOLD, default 10: clocks address is held after BSYNCg asserts.
REQ-003 SHALL have parameter T_DESKEW, default 10: clocks write data is driven before BDOUTg asserts.
REQ-004 SHALL have parameter T_TIMEOUT, default 1000: clocks allowed per BRPLY wait.
REQ-005 SHALL have ports:
- clock  in  1  sole clock; all state on its rising edge.
- RSTN  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1=DATO/DATOB, 0=DATI.
- cmd_byte  in  1  byte write (DATOB); ignored on reads.
- cmd_addr  in  22  Qbus byte address.
- cmd_wdata  in  16  write data.
- rsp_valid  out  1  one-clock completion pulse.
- rsp_rdata  out  16  read data; 0 on writes and on timeout.
- rsp_timeout  out  1  qualifies rsp_valid; no reply was received.
- bus_owned  in  1  DMA ownership (BSACK held) from the grant logic.
- BDALf_IN  in  22  raw BDAL receivers, low = asserted.
- BRPLYf  in  1  raw BRPLY receiver, low = asserted.
- BINITf  in  1  raw BINIT receiver, low = asserted.
- BDALf_OUT  out  22  value to drive.
- BDALf_OE  out  22  driver enables.
- Outbound  out  1  BDAL gate-driver enable.
- BSYNCg, BDINg, BDOUTg, BWTBTg, BBS7g  out  1 each  MOSFET gates, 1 = asserted.

Function
REQ-006 BRPLYf and BINITf SHALL pass through 2-flop synchronizers; "reply" means synchronized BRPLYf == 0.
REQ-007 Command SHALL be accepted on cmd_valid && cmd_ready && bus_owned; all cmd_* fields are latched at acceptance.
REQ-008 States SHALL be IDLE, ADDR, SYNC, DATA, WAIT_RPLY, WAIT_NRPLY, DONE.
REQ-009 ADDR: BDALf_OUT = latched address, OE = 3FFFFF, Outbound = 1, BWTBTg = cmd_write, BBS7g = (addr[21:13] == 9'h1FF); stays T_SETUP clocks, then goes to SYNC.
REQ-010 SYNC: BSYNCg = 1, ADDR outputs held; stays T_HOLD clocks, then goes to DATA.
REQ-011 DATA, read: BDAL released (OE = 0, Outbound = 0), BBS7g = 0, BWTBTg = 0, BDINg = 1; goes to WAIT_RPLY next clock.
REQ-012 DATA, write: BDALf_OUT = {6'b0, wdata}, OE = 3FFFFF, Outbound = 1, BWTBTg = cmd_byte; after T_DESKEW clocks BDOUTg = 1 and goes to WAIT_RPLY.
REQ-013 WAIT_RPLY: on reply, a read SHALL capture rsp_rdata = ~BDALf_IN[15:0] in that clock, then deassert BDINg/BDOUTg and go to WAIT_NRPLY.
REQ-014 WAIT_NRPLY: write data stays driven; on reply negated, goes to DONE.
REQ-015 DONE: BSYNCg = 0, all outputs released; rsp_valid = 1 for one clock; goes to IDLE.
REQ-016 Each wait state SHALL count clocks from entry; at T_TIMEOUT it SHALL go to DONE with rsp_timeout = 1 and rsp_rdata = 0.
REQ-017 BSYNCg SHALL remain asserted continuously from SYNC until DONE.
REQ-018 BDINg and BDOUTg SHALL never both be 1.
REQ-019 If bus_owned falls outside IDLE, the current cycle SHALL complete normally.
REQ-020 Synchronized BINITf low SHALL force IDLE with all gates 0 within 3 clocks, emit no rsp_valid, and hold cmd_ready = 0 while low.
REQ-021 Back-to-back commands SHALL have at least one IDLE clock between them.

Reset
REQ-022 While RSTN = 0: state = IDLE; all gates, OE, Outbound, rsp_valid and rsp_timeout = 0; rsp_rdata = 0; counters = 0.
REQ-023 Deassertion of RSTN SHALL take effect on the next clock; cmd_ready = 1 from that point.

Verification
REQ-024 Read addr 22'o00001000 with reply after 20 clocks and BDALf_IN[15:0] = ~16'o123456 -> sequence SYNC -> BDINg -> rsp_rdata = 16'o123456, timeout = 0, BBS7g never 1.
REQ-025 Byte write addr 22'o17772153 with data 16'hAB00 -> BBS7g = 1 and BWTBTg = 1 in ADDR, BWTBTg = 1 in DATA, BDOUTg rises 10 clocks after DATA entry.
REQ-026 Read with no reply -> rsp_valid exactly 1000 clocks after WAIT_RPLY entry, rsp_timeout = 1, rsp_rdata = 0, BSYNCg = 0.
REQ-027 Reply asserted but never negated -> WAIT_NRPLY timeout, rsp_timeout = 1.
REQ-028 BINITf pulled low mid-WAIT_RPLY -> all gates 0 within 3 clocks, no rsp_valid; RSTN low mid-cycle -> outputs 0 immediately (asynchronous).
REQ-029 cmd_valid = 1 with bus_owned = 0 -> no acceptance, no gate activity; raising bus_owned -> command accepted on the next clock.
